// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic-array matrix-multiply sequencer.
package tpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WREQ,
      WLATCH,
      RUN,
      DONE
   } state_t;

   localparam int DEF_MATRIX_SIZE = 128;
   localparam int DEF_ARRAY_LAT   = 256;

   function automatic int cnt_width(input int msize);
      return $clog2(msize) + 1;
   endfunction

endpackage

// File: rtl/tpu_lat_counter.sv
// Loadable down-counter; o_done rises LAT cycles after i_load and holds until i_clr.
module tpu_lat_counter #(
   parameter int LAT = 256
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   input  logic i_load,
   output logic o_done
);

   localparam int W = $clog2(LAT + 1);

   logic [W-1:0] r_cnt;
   logic         r_arm;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
         r_arm <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_arm <= 1'b0;
      end else if (i_load) begin
         r_cnt <= W'(LAT);
         r_arm <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = r_arm && (r_cnt == '0);

endmodule

// File: rtl/tpu_mm_sequencer.sv
// Sequences one weight-stationary matmul: weight pop, latch, row issue, delayed result writes.
module tpu_mm_sequencer
   import tpu_pkg::*;
#(
   parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
   parameter int ADDRESSSIZE = 10,
   parameter int ARRAY_LAT   = DEF_ARRAY_LAT,
   parameter int CNT_W       = cnt_width(MATRIX_SIZE)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_rows,
   input  logic [ADDRESSSIZE-1:0] act_base,
   input  logic [ADDRESSSIZE-1:0] res_base,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   we_rl,
   output logic [ADDRESSSIZE-1:0] act_addr,
   output logic                   valid_address,
   output logic                   res_we,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic                   busy,
   output logic                   end_,
   output logic                   err
);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_n;
   logic [CNT_W-1:0]       r_icnt;
   logic [CNT_W-1:0]       r_wcnt;
   logic [ADDRESSSIZE-1:0] r_ab;
   logic [ADDRESSSIZE-1:0] r_rb;
   logic                   r_fre;
   logic                   r_we_rl;
   logic                   r_valid;
   logic [ADDRESSSIZE-1:0] r_act_addr;
   logic                   r_res_we;
   logic [ADDRESSSIZE-1:0] r_res_addr;
   logic                   r_busy;
   logic                   r_end;
   logic                   r_err;

   logic w_lat_load;
   logic w_lat_clr;
   logic w_lat_done;

   // Write side is armed the same edge that enters RUN; it fires exactly
   // ARRAY_LAT edges after the first issue edge.
   assign w_lat_load = (r_state == WLATCH) && (r_n != '0);
   assign w_lat_clr  = (r_state == DONE);

   tpu_lat_counter #(
      .LAT (ARRAY_LAT)
   ) u_lat (
      .clk    (clk),
      .rstn   (rstn),
      .i_clr  (w_lat_clr),
      .i_load (w_lat_load),
      .o_done (w_lat_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_n        <= '0;
         r_icnt     <= '0;
         r_wcnt     <= '0;
         r_ab       <= '0;
         r_rb       <= '0;
         r_fre      <= 1'b0;
         r_we_rl    <= 1'b0;
         r_valid    <= 1'b0;
         r_act_addr <= '0;
         r_res_we   <= 1'b0;
         r_res_addr <= '0;
         r_busy     <= 1'b0;
         r_end      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_fre      <= 1'b0;
         r_we_rl    <= 1'b0;
         r_valid    <= 1'b0;
         r_act_addr <= '0;
         r_res_we   <= 1'b0;
         r_res_addr <= '0;
         r_end      <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (start) begin
                  if (num_rows > CNT_W'(MATRIX_SIZE)) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err   <= 1'b0;
                     r_n     <= num_rows;
                     r_ab    <= act_base;
                     r_rb    <= res_base;
                     r_icnt  <= '0;
                     r_wcnt  <= '0;
                     r_busy  <= 1'b1;
                     r_state <= WREQ;
                  end
               end
            end
            WREQ: begin
               if (!fifo_empty) begin
                  r_fre   <= 1'b1;
                  r_state <= WLATCH;
               end
            end
            WLATCH: begin
               r_we_rl <= 1'b1;
               r_state <= (r_n == '0) ? DONE : RUN;
            end
            RUN: begin
               if (r_icnt != r_n) begin
                  r_valid    <= 1'b1;
                  r_act_addr <= r_ab + ADDRESSSIZE'(r_icnt);
                  r_icnt     <= r_icnt + 1'b1;
               end
               if (w_lat_done && (r_wcnt != r_n)) begin
                  r_res_we   <= 1'b1;
                  r_res_addr <= r_rb + ADDRESSSIZE'(r_wcnt);
                  r_wcnt     <= r_wcnt + 1'b1;
                  if (r_wcnt + 1'b1 == r_n) r_state <= DONE;
               end
            end
            DONE: begin
               r_end   <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fifo_read_enable = r_fre;
   assign we_rl            = r_we_rl;
   assign act_addr         = r_act_addr;
   assign valid_address    = r_valid;
   assign res_we           = r_res_we;
   assign res_addr         = r_res_addr;
   assign busy             = r_busy;
   assign end_             = r_end;
   assign err              = r_err;

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// Directed bench for tpu_mm_sequencer (MATRIX_SIZE=4, ARRAY_LAT=6, ADDRESSSIZE=10).
module tb_tpu_mm_sequencer;

   localparam int MS  = 4;
   localparam int AW  = 10;
   localparam int LAT = 6;
   localparam int CW  = 3;

   typedef struct packed {
      logic          fre;
      logic          wl;
      logic          va;
      logic [AW-1:0] act;
      logic          rwe;
      logic [AW-1:0] radr;
      logic          busy;
      logic          done;
      logic          err;
   } obs_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_rows = '0;
   logic [AW-1:0] act_base = '0;
   logic [AW-1:0] res_base = '0;
   logic          fifo_empty = 1'b0;
   logic          fifo_read_enable;
   logic          we_rl;
   logic [AW-1:0] act_addr;
   logic          valid_address;
   logic          res_we;
   logic [AW-1:0] res_addr;
   logic          busy;
   logic          end_;
   logic          err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tpu_mm_sequencer #(
      .MATRIX_SIZE (MS),
      .ADDRESSSIZE (AW),
      .ARRAY_LAT   (LAT),
      .CNT_W       (CW)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .num_rows         (num_rows),
      .act_base         (act_base),
      .res_base         (res_base),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .we_rl            (we_rl),
      .act_addr         (act_addr),
      .valid_address    (valid_address),
      .res_we           (res_we),
      .res_addr         (res_addr),
      .busy             (busy),
      .end_             (end_),
      .err              (err)
   );

   function automatic obs_t sample();
      obs_t o;
      o.fre  = fifo_read_enable;
      o.wl   = we_rl;
      o.va   = valid_address;
      o.act  = act_addr;
      o.rwe  = res_we;
      o.radr = res_addr;
      o.busy = busy;
      o.done = end_;
      o.err  = err;
      return o;
   endfunction

   // k = cycles since the accepting edge; s = empty-FIFO stall cycles
   function automatic obs_t model(int k, int n, logic [AW-1:0] ab,
                                  logic [AW-1:0] rb, int s);
      obs_t e;
      int   ek;
      e  = '0;
      ek = (n == 0) ? 3 + s : 3 + s + LAT + n;
      if (k < 0) return e;
      e.fre = (k == 1 + s);
      e.wl  = (k == 2 + s);
      if (k >= 3 + s && k < 3 + s + n) begin
         e.va  = 1'b1;
         e.act = ab + AW'(k - 3 - s);
      end
      if (k >= 3 + s + LAT && k < 3 + s + LAT + n) begin
         e.rwe  = 1'b1;
         e.radr = rb + AW'(k - 3 - s - LAT);
      end
      e.done = (k == ek);
      e.busy = (k <= ek);
      return e;
   endfunction

   task automatic test_reset();
      obs_t got;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'('0)) begin
         errors++;
         $display("FAIL reset got=%h exp=0", got);
      end
      rstn = 1'b1;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'('0)) begin
         errors++;
         $display("FAIL reset_idle got=%h exp=0", got);
      end
   endtask

   task automatic test_basic();
      obs_t got, exp;
      num_rows = 3'd4; act_base = 10'd0; res_base = 10'h10;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         start = 1'b0;
         got = sample();
         exp = model(k, 4, 10'd0, 10'h10, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_stall();
      obs_t got, exp;
      num_rows = 3'd2; act_base = 10'd5; res_base = 10'h20;
      fifo_empty = 1'b1;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 5) fifo_empty = 1'b0;
         got = sample();
         exp = model(k, 2, 10'd5, 10'h20, 5);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL stall k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_zero_rows();
      obs_t got, exp;
      num_rows = 3'd0; act_base = 10'd7; res_base = 10'd9;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         got = sample();
         exp = model(k, 0, 10'd7, 10'd9, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL zero_rows k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_err();
      obs_t got, exp;
      num_rows = 3'd5; act_base = 10'd1; res_base = 10'd2;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         got = sample();
         exp = '0;
         exp.err = 1'b1;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL err k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_wrap();
      obs_t got, exp;
      num_rows = 3'd3; act_base = 10'd1022; res_base = 10'd1023;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         start = 1'b0;
         got = sample();
         exp = model(k, 3, 10'd1022, 10'd1023, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL wrap k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_busy_start();
      obs_t got, exp;
      num_rows = 3'd4; act_base = 10'h30; res_base = 10'h38;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         start = (k == 5);
         if (k == 5) num_rows = 3'd1;
         got = sample();
         exp = model(k, 4, 10'h30, 10'h38, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL busy_start k=%0d got=%h exp=%h", k, got, exp);
         end
      end
      start = 1'b0;
   endtask

   // start held high: next job accepted the cycle after end_ (edge 11)
   task automatic test_back_to_back();
      obs_t got, exp;
      num_rows = 3'd1; act_base = 10'h40; res_base = 10'h50;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         if (k == 0) begin
            num_rows = 3'd2; act_base = 10'h60; res_base = 10'h70;
         end
         if (k == 11) start = 1'b0;
         got = sample();
         exp = model(k, 1, 10'h40, 10'h50, 0) |
               model(k - 11, 2, 10'h60, 10'h70, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t got, exp;
      num_rows = 3'd4; act_base = 10'd0; res_base = 10'h10;
      start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         got = sample();
         exp = model(k, 4, 10'd0, 10'h10, 0);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset k=%0d got=%h exp=%h", k, got, exp);
         end
      end
      #2 rstn = 1'b0;
      #1 got = sample();
      checks++;
      if (got !== obs_t'('0)) begin
         errors++;
         $display("FAIL async_reset got=%h exp=0", got);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== obs_t'('0)) begin
            errors++;
            $display("FAIL post_reset k=%0d got=%h exp=0", k, got);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_rows();
      test_err();
      test_wrap();
      test_busy_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
